el_link_fifo: RTL
=================

EL_LINK_FIFO -- requirements
Module: el_link_fifo

Interface
REQ-001 The block SHALL have parameter LINK_WIDTH, default 2, meaning the number of multi-rail digits per token.
REQ-002 The block SHALL have parameter RAIL_NUM, default 2, meaning rails per digit (1-of-RAIL_NUM code, RAIL_NUM >= 2).
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning FIFO entries (DEPTH >= 2, any integer).
REQ-004 The block SHALL have parameter SYNC_STAGES, default 2, meaning flops per synchroniser on in and ack_i (>= 2).
REQ-005 clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset; asynchronous and active-high.
REQ-007 in  input  LINK_WIDTH*RAIL_NUM  2-phase multi-rail input link; digit d occupies bits [RAIL_NUM*d +: RAIL_NUM].
REQ-008 ack_o  output  1  2-phase acknowledge to the input-link sender.
REQ-009 out  output  LINK_WIDTH*RAIL_NUM  2-phase multi-rail output link, same packing as in.
REQ-010 ack_i  input  1  2-phase acknowledge from the output-link receiver.
REQ-011 count  output  clog2(DEPTH+1)  FIFO occupancy.
REQ-012 err  output  1  sticky code-violation flag.

Function
REQ-013 in and ack_i SHALL each pass through SYNC_STAGES flops before any use; the synchronised values are in_s and ack_s.
REQ-014 An input reference register in_ref SHALL hold the last accepted in_s; per digit, delta = in_s XOR in_ref slice.
REQ-015 A token SHALL be complete when every digit's delta has exactly one bit set; a digit with zero bits set means "not yet arrived" (rail skew tolerated).
REQ-016 Any digit with two or more delta bits set SHALL set err at the next edge; the token SHALL NOT be accepted and in_ref SHALL NOT update.
REQ-017 A complete token SHALL be accepted at the next edge iff count < DEPTH (before that edge); on accept: the per-digit value (index of the set delta bit, clog2(RAIL_NUM) bits) is written to the FIFO, in_ref <= in_s, ack_o toggles.
REQ-018 When count == DEPTH a complete token SHALL be held (no ack_o toggle) and accepted at the first edge where count < DEPTH.
REQ-019 An output-pending flag pend SHALL be set on launch and cleared at the edge where ack_s != ack_ref, with ack_ref <= ack_s at that edge.
REQ-020 When count > 0 and pend == 0, the head entry SHALL be popped and, at the same edge, out SHALL toggle exactly one rail per digit (rail = stored value) and pend SHALL set.
REQ-021 Simultaneous accept and pop in one cycle SHALL both take effect; count remains unchanged.
REQ-022 A FIFO pointer SHALL wrap from DEPTH-1 to 0; DEPTH need not be a power of two.
REQ-023 Latency: an in transition SHALL produce an ack_o toggle SYNC_STAGES+1 edges after it is sampled; with an empty FIFO and pend == 0, out SHALL toggle one edge after the accept.
REQ-024 Tokens SHALL leave in acceptance order; none dropped or duplicated.

Reset
REQ-025 While rst is high: out = 0, ack_o = 0, count = 0, err = 0, pend = 0, in_ref = 0, ack_ref = 0, pointers = 0, all synchroniser flops = 0, asynchronously.
REQ-026 Reset mid-transfer SHALL discard all FIFO contents and pending handshakes; the link partners are reset together with the block.
REQ-027 err SHALL clear only on reset.

Verification (LINK_WIDTH=2, RAIL_NUM=2, DEPTH=4, SYNC_STAGES=2)
REQ-028 Single token: after reset, in = 4'b1001 -> ack_o = 1 three edges later, out = 4'b1001 one edge after that, count returns to 0.
REQ-029 Skew: toggle in[0], wait 10 cycles, toggle in[3] -> no ack_o change during the wait; ack_o toggles 3 edges after in[3].
REQ-030 Back-pressure: ack_i held at 0, six tokens sent -> first launches to out, next four fill FIFO (count = 4), sixth not acked; one ack_i toggle -> pop, count 3 then 4, sixth acked.
REQ-031 Code violation: toggle in[0] and in[1] together -> err = 1, ack_o unchanged, count = 0; err stays 1 until rst.
REQ-032 Ordering/wrap: send 10 distinct tokens with ack_i toggled after each out change -> out rail changes reproduce input values in order; pointers wrap twice.
REQ-033 Reset mid-operation: assert rst with count = 3 -> out = 0, ack_o = 0, count = 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/el_link_fifo_if.sv
// el_link_fifo_if: groups the two 2-phase multi-rail links and the status outputs of
// el_link_fifo.
//   in     : input link from the sender (LINK_WIDTH digits of RAIL_NUM rails)
//   ack_o  : 2-phase acknowledge back to the sender
//   out    : output link to the receiver, same packing as in
//   ack_i  : 2-phase acknowledge from the receiver
//   count  : FIFO occupancy
//   err    : sticky code-violation flag
// Modports: slave is the FIFO side, master is the link-partner side.
interface el_link_fifo_if #(
  parameter int unsigned LINK_WIDTH = 2,
  parameter int unsigned RAIL_NUM   = 2,
  parameter int unsigned DEPTH      = 4
);
  localparam int unsigned W  = LINK_WIDTH * RAIL_NUM;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  in;
  logic          ack_o;
  logic [W-1:0]  out;
  logic          ack_i;
  logic [CW-1:0] count;
  logic          err;

  modport slave (
    input  in, ack_i,
    output ack_o, out, count, err
  );

  modport master (
    output in, ack_i,
    input  ack_o, out, count, err
  );
endinterface

// File: rtl/el_link_fifo.sv
// el_link_fifo: clocked FIFO bridging two 2-phase 1-of-RAIL_NUM multi-rail links.
// A token arrives as one rail transition per digit on link.in (skew between digits is
// tolerated), is acknowledged on link.ack_o, stored as per-digit rail indices, and
// replayed as one rail transition per digit on link.out once the receiver has
// acknowledged the previous token via link.ack_i.
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-high reset
//   link : el_link_fifo_if.slave (in, ack_o, out, ack_i, count, err)
module el_link_fifo #(
  parameter int unsigned LINK_WIDTH  = 2,
  parameter int unsigned RAIL_NUM    = 2,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          rst,
  el_link_fifo_if.slave link
);
  localparam int unsigned W  = LINK_WIDTH * RAIL_NUM;
  localparam int unsigned VW = $clog2(RAIL_NUM);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [PW-1:0] LastPtr = PW'(DEPTH - 1);

  // Synchronisers: element 0 takes the raw input, element SYNC_STAGES-1 is the output.
  logic [SYNC_STAGES-1:0][W-1:0] in_sync_q;
  logic [SYNC_STAGES-1:0]        ack_sync_q;
  logic [W-1:0]                  in_s;
  logic                          ack_s;

  logic [W-1:0]            in_ref_q, in_ref_d;
  logic                    ack_ref_q, ack_ref_d;
  logic                    pend_q, pend_d;
  logic                    ack_o_q, ack_o_d;
  logic [W-1:0]            out_q, out_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    err_q, err_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [LINK_WIDTH*VW-1:0] mem_q [DEPTH];

  logic [W-1:0]             delta;
  logic                     complete;
  logic                     viol;
  logic [LINK_WIDTH*VW-1:0] wr_val;
  logic [LINK_WIDTH*VW-1:0] rd_val;
  logic                     accept;
  logic                     pop;
  logic                     ack_evt;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_sync_q  <= '0;
      ack_sync_q <= '0;
    end else begin
      in_sync_q  <= {in_sync_q[SYNC_STAGES-2:0], link.in};
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], link.ack_i};
    end
  end

  assign in_s  = in_sync_q[SYNC_STAGES-1];
  assign ack_s = ack_sync_q[SYNC_STAGES-1];
  assign delta = in_s ^ in_ref_q;

  // Per-digit classification: 0 transitions = still in flight, 1 = arrived, >1 = illegal.
  always_comb begin
    complete = 1'b1;
    viol     = 1'b0;
    wr_val   = '0;
    for (int d = 0; d < int'(LINK_WIDTH); d++) begin
      if ($countones(delta[RAIL_NUM*d +: RAIL_NUM]) == 0) begin
        complete = 1'b0;
      end else if ($countones(delta[RAIL_NUM*d +: RAIL_NUM]) > 1) begin
        viol = 1'b1;
      end
      for (int r = 0; r < int'(RAIL_NUM); r++) begin
        if (delta[RAIL_NUM*d + r]) wr_val[VW*d +: VW] = VW'(r);
      end
    end
  end

  assign rd_val  = mem_q[rd_ptr_q];
  assign accept  = complete && !viol && (count_q < DepthC);
  assign pop     = (count_q != '0) && !pend_q;
  assign ack_evt = (ack_s != ack_ref_q);

  always_comb begin
    in_ref_d  = in_ref_q;
    ack_ref_d = ack_ref_q;
    pend_d    = pend_q;
    ack_o_d   = ack_o_q;
    out_d     = out_q;
    count_d   = count_q;
    err_d     = err_q | viol;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;

    if (accept) begin
      in_ref_d = in_s;
      ack_o_d  = ~ack_o_q;
      wr_ptr_d = next_ptr(wr_ptr_q);
    end

    if (ack_evt) begin
      ack_ref_d = ack_s;
      pend_d    = 1'b0;
    end

    // Launch: one rail flip per digit on the rail named by the stored index.
    if (pop) begin
      pend_d   = 1'b1;
      rd_ptr_d = next_ptr(rd_ptr_q);
      for (int d = 0; d < int'(LINK_WIDTH); d++) begin
        for (int r = 0; r < int'(RAIL_NUM); r++) begin
          if (rd_val[VW*d +: VW] == VW'(r)) out_d[RAIL_NUM*d + r] = ~out_q[RAIL_NUM*d + r];
        end
      end
    end

    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ref_q  <= '0;
      ack_ref_q <= 1'b0;
      pend_q    <= 1'b0;
      ack_o_q   <= 1'b0;
      out_q     <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      in_ref_q  <= in_ref_d;
      ack_ref_q <= ack_ref_d;
      pend_q    <= pend_d;
      ack_o_q   <= ack_o_d;
      out_q     <= out_d;
      count_q   <= count_d;
      err_q     <= err_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= wr_val;
  end

  assign link.ack_o = ack_o_q;
  assign link.out   = out_q;
  assign link.count = count_q;
  assign link.err   = err_q;
endmodule
